// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   load_state_e   : loader FSM states (header bytes, data bytes, finished)
//   HDR_BYTES      : length of the word-count header in bytes
//   BYTES_PER_WORD : bytes packed into one instruction word
//   word_byte_addr : byte address of the idx-th word above a base address
package mips_pkg;

  typedef enum logic [1:0] {
    HDR0 = 2'd0,
    HDR1 = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } load_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

  // Word index to byte address; the sum wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [16:0] idx);
    return base + {13'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Bundle of the loader's byte-stream and instruction-memory signals.
//   rx_data/rx_valid/rx_ready : byte stream handshake from the byte source
//   start                     : restart pulse, honoured only once a load is done
//   imem_wr_en/addr/wdata     : instruction memory write port
//   cpu_reset/load_done/load_err : processor reset and load status
// master is the loader's view, slave is the byte source / memory / CPU side.
interface imem_boot_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start;
  logic        imem_wr_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  modport master (
    input  rx_data, rx_valid, start,
    output rx_ready, imem_wr_en, imem_addr, imem_wdata,
           cpu_reset, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid, start,
    input  rx_ready, imem_wr_en, imem_addr, imem_wdata,
           cpu_reset, load_done, load_err
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs accepted bytes into big-endian words.
//   clk, reset     : clock and asynchronous active-high reset
//   clear_i        : holds the byte index at zero (used outside the data phase)
//   byte_valid_i   : a byte is accepted this cycle
//   byte_i         : accepted byte
//   word_o         : word completed by the current byte (valid with word_valid_o)
//   word_valid_o   : the current byte is the last byte of a word
module byte_word_packer
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 word_valid_o
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  // Only the first three bytes of a word need storing; the fourth is
  // combined straight from the input when the word completes.
  logic [WORD_BITS-9:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // Shift in each accepted byte below the previous ones so the first byte
  // of a word ends up in the top byte; the index wraps naturally 3 -> 0.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[WORD_BITS-17:0], byte_i};
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  // State register; reset discards any partially assembled word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && !clear_i &&
                        (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes the words into
// instruction memory and keeps the processor in reset until the load ends.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : byte stream, memory write port and status (master modport)
// Parameters: DEPTH_WORDS (memory capacity in words), BASE_ADDR (first word).
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.master  bus
);

  load_state_e              state_q, state_d;
  logic [8*HDR_BYTES-1:0]   n_q, n_d;
  logic [16:0]              words_q, words_d;
  logic                     wr_en_q, wr_en_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     cpu_reset_q, cpu_reset_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic [WORD_BITS-1:0]     word;
  logic                     word_valid;
  logic [8*HDR_BYTES-1:0]   n_next;
  logic                     last_word;
  logic                     in_range;

  assign bus.rx_ready = !reset && (state_q != DONE);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign n_next       = {n_q[8*HDR_BYTES-9:0], bus.rx_data};
  assign last_word    = (words_q + 17'd1) == {1'b0, n_q};
  assign in_range     = words_q < 17'(DEPTH_WORDS);

  byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (state_q != DATA),
    .byte_valid_i (accept),
    .byte_i       (bus.rx_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Next-state and output logic. Header bytes are shifted into N most
  // significant byte first. A completed word is written only while it fits
  // in memory; beyond that it is still counted so the stream is consumed to
  // its end, and the overflow flag is raised. In DONE the processor is
  // released one cycle after entering, so the final write lands first.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    words_d     = words_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      HDR0: begin
        if (accept) begin
          n_d     = n_next;
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          n_d     = n_next;
          words_d = '0;
          state_d = (n_next == '0) ? DONE : DATA;
        end
      end
      DATA: begin
        if (word_valid) begin
          if (in_range) begin
            wr_en_d = 1'b1;
            wdata_d = word;
            addr_d  = word_byte_addr(BASE_ADDR, words_q);
          end else begin
            err_d = 1'b1;
          end
          words_d = words_q + 17'd1;
          if (last_word) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d     = HDR0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          addr_d      = BASE_ADDR;
        end else begin
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HDR0;
      n_q         <= '0;
      words_q     <= '0;
      wr_en_q     <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      words_q     <= words_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.imem_wr_en = wr_en_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: a full-size loader (dut1) and a two-word
// loader (dut2) share clock, reset and the byte driver; sel picks the target.
module tb_imem_boot_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic [7:0] rxData;
  logic       rxValid;
  logic       startPulse;

  imem_boot_loader_if bif1 ();
  imem_boot_loader_if bif2 ();

  imem_boot_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut1 (
    .clk(clk), .reset(reset), .bus(bif1)
  );
  imem_boot_loader #(.DEPTH_WORDS(2), .BASE_ADDR(32'h0000_0000)) dut2 (
    .clk(clk), .reset(reset), .bus(bif2)
  );

  assign bif1.rx_data  = rxData;
  assign bif1.rx_valid = rxValid && !sel;
  assign bif1.start    = startPulse && !sel;
  assign bif2.rx_data  = rxData;
  assign bif2.rx_valid = rxValid && sel;
  assign bif2.start    = startPulse && sel;

  logic rdy, curDone, curCpuRst, curErr;
  assign rdy       = sel ? bif2.rx_ready  : bif1.rx_ready;
  assign curDone   = sel ? bif2.load_done : bif1.load_done;
  assign curCpuRst = sel ? bif2.cpu_reset : bif1.cpu_reset;
  assign curErr    = sel ? bif2.load_err  : bif1.load_err;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [63:0] wq1[$];
  logic [63:0] wq2[$];

  // Record every write pulse as {addr, data}, sampled mid-cycle.
  always @(negedge clk) begin
    if (bif1.imem_wr_en) wq1.push_back({bif1.imem_addr, bif1.imem_wdata});
    if (bif2.imem_wr_en) wq2.push_back({bif2.imem_addr, bif2.imem_wdata});
  end

  typedef struct {
    string            name;
    logic [15:0]      n;
    logic [2:0][31:0] words;
    int               expWrites;
    bit               gaps;
  } loadVec_t;

  loadVec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one byte (optionally after random idle cycles) and hold it until
  // the selected loader accepts it on a rising edge.
  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    int waitCnt;
    @(negedge clk);
    if (gaps) begin
      rxValid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rxData  = b;
    rxValid = 1'b1;
    waitCnt = 0;
    while (!rdy && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rdy) begin
      checkOutput("rx_ready timeout", 32'(rdy), 32'd1);
      rxValid = 1'b0;
    end else begin
      @(posedge clk);
      #1 rxValid = 1'b0;
    end
  endtask

  task automatic sendLoad(input logic [15:0] n, input logic [2:0][31:0] words,
                          input bit gaps);
    applyStimulus(n[15:8], gaps);
    applyStimulus(n[7:0], gaps);
    for (int w = 0; w < int'(n) && w < 3; w++)
      for (int b = 3; b >= 0; b--)
        applyStimulus(words[w][8*b +: 8], gaps);
  endtask

  task automatic waitDone(input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (!curDone && c < 40) begin
      @(negedge clk);
      c++;
    end
    checkOutput({name, " load_done"}, 32'(curDone), 32'd1);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    startPulse = 1'b1;
    @(negedge clk);
    startPulse = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"three words gaps", 16'd3,
                {32'hFFEE_0080, 32'hA5B6_C7D8, 32'h0102_0304}, 3, 1'b1};
    vecs[1] = '{"empty load", 16'd0, {32'h0, 32'h0, 32'h0}, 0, 1'b0};
    vecs[2] = '{"one word gaps", 16'd1, {32'h0, 32'h0, 32'hCAFE_BABE}, 1, 1'b1};
    vecs[3] = '{"two words", 16'd2,
                {32'h0, 32'h9ABC_DEF0, 32'h1234_5678}, 2, 1'b0};

    reset = 1'b1; sel = 1'b0; rxData = '0; rxValid = 1'b0; startPulse = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset rx_ready",  32'(bif1.rx_ready),   32'd0);
    checkOutput("reset cpu_reset", 32'(bif1.cpu_reset),  32'd1);
    checkOutput("reset load_done", 32'(bif1.load_done),  32'd0);
    checkOutput("reset load_err",  32'(bif1.load_err),   32'd0);
    checkOutput("reset wr_en",     32'(bif1.imem_wr_en), 32'd0);
    checkOutput("reset addr",      bif1.imem_addr,       32'h0);
    checkOutput("reset wdata",     bif1.imem_wdata,      32'h0);
    reset = 1'b0;
    #1 checkOutput("ready after reset", 32'(bif1.rx_ready), 32'd1);

    // 00 01 DE AD BE EF: write on the cycle after the last byte, release a
    // cycle later, and bytes offered in DONE are ignored.
    sendLoad(16'd1, {32'h0, 32'h0, 32'hDEAD_BEEF}, 1'b0);
    @(negedge clk);
    checkOutput("A wr_en T+1",     32'(bif1.imem_wr_en), 32'd1);
    checkOutput("A addr T+1",      bif1.imem_addr,       32'h0);
    checkOutput("A wdata T+1",     bif1.imem_wdata,      32'hDEAD_BEEF);
    checkOutput("A cpu_reset T+1", 32'(bif1.cpu_reset),  32'd1);
    checkOutput("A load_done T+1", 32'(bif1.load_done),  32'd0);
    checkOutput("A rx_ready T+1",  32'(bif1.rx_ready),   32'd0);
    @(negedge clk);
    checkOutput("A cpu_reset T+2", 32'(bif1.cpu_reset),  32'd0);
    checkOutput("A load_done T+2", 32'(bif1.load_done),  32'd1);
    checkOutput("A wr_en T+2",     32'(bif1.imem_wr_en), 32'd0);
    rxData = 8'h55; rxValid = 1'b1;
    repeat (4) @(negedge clk);
    rxValid = 1'b0;
    checkOutput("A writes",          32'(wq1.size()),      32'd1);
    checkOutput("A done held",       32'(bif1.load_done),  32'd1);
    checkOutput("A cpu_reset held",  32'(bif1.cpu_reset),  32'd0);

    // Table of restarted loads on the full-size loader.
    for (int i = 0; i < 4; i++) begin
      pulseStart();
      checkOutput({vecs[i].name, " start cpu_reset"}, 32'(bif1.cpu_reset), 32'd1);
      checkOutput({vecs[i].name, " start load_done"}, 32'(bif1.load_done), 32'd0);
      wq1.delete();
      sendLoad(vecs[i].n, vecs[i].words, vecs[i].gaps);
      waitDone(vecs[i].name);
      checkOutput({vecs[i].name, " writes"}, 32'(wq1.size()), 32'(vecs[i].expWrites));
      for (int j = 0; j < wq1.size() && j < 3; j++) begin
        checkOutput({vecs[i].name, " addr"}, wq1[j][63:32], 32'(4 * j));
        checkOutput({vecs[i].name, " data"}, wq1[j][31:0], vecs[i].words[j]);
      end
      checkOutput({vecs[i].name, " load_err"},  32'(bif1.load_err),  32'd0);
      checkOutput({vecs[i].name, " cpu_reset"}, 32'(bif1.cpu_reset), 32'd0);
    end

    // Header 00 00: DONE straight after the header, released a cycle later.
    pulseStart();
    wq1.delete();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    @(negedge clk);
    checkOutput("B rx_ready T+1",  32'(bif1.rx_ready),  32'd0);
    checkOutput("B cpu_reset T+1", 32'(bif1.cpu_reset), 32'd1);
    checkOutput("B load_done T+1", 32'(bif1.load_done), 32'd0);
    @(negedge clk);
    checkOutput("B cpu_reset T+2", 32'(bif1.cpu_reset), 32'd0);
    checkOutput("B load_done T+2", 32'(bif1.load_done), 32'd1);
    checkOutput("B writes",        32'(wq1.size()),     32'd0);

    // Reset after two data bytes, then a clean reload.
    pulseStart();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("C reset rx_ready",  32'(bif1.rx_ready),  32'd0);
    checkOutput("C reset cpu_reset", 32'(bif1.cpu_reset), 32'd1);
    checkOutput("C reset wdata",     bif1.imem_wdata,     32'h0);
    checkOutput("C reset addr",      bif1.imem_addr,      32'h0);
    @(negedge clk);
    reset = 1'b0;
    wq1.delete();
    sendLoad(16'd1, {32'h0, 32'h0, 32'h1122_3344}, 1'b0);
    waitDone("C");
    checkOutput("C writes", 32'(wq1.size()), 32'd1);
    if (wq1.size() > 0) begin
      checkOutput("C addr", wq1[0][63:32], 32'h0);
      checkOutput("C data", wq1[0][31:0],  32'h1122_3344);
    end

    // Two-word loader fed three words: overflow, then a restart clears it.
    sel = 1'b1;
    wq2.delete();
    sendLoad(16'd3, {32'h7788_99AA, 32'h3344_5566, 32'hC001_D00D}, 1'b1);
    waitDone("D");
    checkOutput("D writes",    32'(wq2.size()), 32'd2);
    if (wq2.size() >= 2) begin
      checkOutput("D addr0", wq2[0][63:32], 32'h0);
      checkOutput("D data0", wq2[0][31:0],  32'hC001_D00D);
      checkOutput("D addr1", wq2[1][63:32], 32'h4);
      checkOutput("D data1", wq2[1][31:0],  32'h3344_5566);
    end
    checkOutput("D load_err",  32'(curErr),    32'd1);
    checkOutput("D cpu_reset", 32'(curCpuRst), 32'd0);
    pulseStart();
    checkOutput("E start load_err",  32'(curErr),         32'd0);
    checkOutput("E start cpu_reset", 32'(curCpuRst),      32'd1);
    checkOutput("E start addr",      bif2.imem_addr,      32'h0);
    wq2.delete();
    sendLoad(16'd1, {32'h0, 32'h0, 32'hCAFE_BABE}, 1'b0);
    waitDone("E");
    checkOutput("E writes", 32'(wq2.size()), 32'd1);
    if (wq2.size() > 0) begin
      checkOutput("E addr", wq2[0][63:32], 32'h0);
      checkOutput("E data", wq2[0][31:0],  32'hCAFE_BABE);
    end
    checkOutput("E load_err", 32'(curErr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
